collision_scheduler: RTL

//  Per-frame sequencer that shares one collision-check datapath across an obstacle table.
//  On each frame tick it snapshots the ship position, then walks obstacle entries 0..NUM_OBS-1.

---
 rtl/collision_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/collision_scheduler.sv
// Per-frame collision scan sequencer: walks the obstacle table through one shared checker.
// Optional build macro COLSCHED_SKIP_INVALID_EN skips entries whose obs_valid is low.
module collision_scheduler #(
  parameter  int NUM_OBS = 4,
  localparam int IDX_W   = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             game_restart,
  input  logic [7:0]       ship_x,
  input  logic [6:0]       ship_y,
  output logic             obs_rd_en,
  output logic [IDX_W-1:0] obs_rd_idx,
  input  logic [7:0]       obs_x,
  input  logic [6:0]       obs_y,
  input  logic [7:0]       obs_height,
  input  logic [4:0]       obs_width,
  input  logic             obs_valid,
  output logic             chk_clear,
  output logic             chk_en,
  output logic [7:0]       chk_ship_x,
  output logic [6:0]       chk_ship_y,
  output logic [7:0]       chk_obs_x,
  output logic [6:0]       chk_obs_y,
  output logic [7:0]       chk_height,
  output logic [4:0]       chk_width,
  input  logic             chk_crash,
  output logic             busy,
  output logic             done,
  output logic             crash,
  output logic [IDX_W-1:0] crash_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    CHECK,
    SAMPLE,
    DONE,
    HALT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             last_entry;
  logic             skip_entry;

  assign last_entry = (idx == LAST_IDX);

`ifdef COLSCHED_SKIP_INVALID_EN
  assign skip_entry = ~obs_valid;
`else
  logic unused_obs_valid;
  assign unused_obs_valid = obs_valid;
  assign skip_entry       = 1'b0;
`endif

  // Next-state logic; game_restart overrides every other transition.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (frame_tick) next_state = FETCH;
      FETCH:   next_state = LATCH;
      LATCH: begin
        if (skip_entry) next_state = last_entry ? DONE : FETCH;
        else            next_state = CHECK;
      end
      CHECK:   next_state = SAMPLE;
      SAMPLE: begin
        if (chk_crash)       next_state = HALT;
        else if (last_entry) next_state = DONE;
        else                 next_state = FETCH;
      end
      DONE:    next_state = IDLE;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
    if (game_restart) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      crash      <= 1'b0;
      crash_idx  <= '0;
      chk_clear  <= 1'b0;
      chk_ship_x <= '0;
      chk_ship_y <= '0;
      chk_obs_x  <= '0;
      chk_obs_y  <= '0;
      chk_height <= '0;
      chk_width  <= '0;
    end else begin
      state     <= next_state;
      chk_clear <= game_restart;
      if (game_restart) begin
        idx       <= '0;
        crash     <= 1'b0;
        crash_idx <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (frame_tick) begin
              chk_ship_x <= ship_x;
              chk_ship_y <= ship_y;
              idx        <= '0;
            end
          end
          LATCH: begin
            chk_obs_x  <= obs_x;
            chk_obs_y  <= obs_y;
            chk_height <= obs_height;
            chk_width  <= obs_width;
            if (skip_entry && !last_entry) idx <= idx + 1'b1;
          end
          SAMPLE: begin
            // Checker flag is sticky, so sampling one cycle after chk_en sees this entry's result.
            if (chk_crash) begin
              crash     <= 1'b1;
              crash_idx <= idx;
            end else if (!last_entry) begin
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign obs_rd_en  = (state == FETCH);
  assign obs_rd_idx = idx;
  assign chk_en     = (state == CHECK);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE) && (state != HALT);

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset) !(obs_rd_en && chk_en));
  a_idx_in_range:      assert property (@(posedge clk) disable iff (reset) idx <= LAST_IDX);

endmodule
